// File: rtl/onehot_enc_pkg.sv
// Shared types, widths and helpers for the one-hot select encoder.
package onehot_enc_pkg;

  localparam int CODE_W            = 3;
  localparam int SEL_W             = 7;
  localparam int CNT_W             = 8;
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int STABLE_CYCLES_DEF = 4;

  localparam logic [CODE_W-1:0] ERR_CODE = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD,
    RELEASE
  } state_e;

  function automatic logic is_onehot(input logic [SEL_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [SEL_W-1:0] v);
    logic [CODE_W-1:0] enc;
    enc = '0;
    for (int i = 0; i < SEL_W; i++) begin
      if (v[i]) enc = CODE_W'(i);
    end
    return enc;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-bit, multi-stage flop synchronizer with asynchronous reset to zero.
module bit_synchronizer #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], d};
  end

  // NOTE: every stage resets to zero so a reset looks like an all-zero select downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/onehot_select_encoder.sv
// Synchronizes an asynchronous one-hot select, debounces it, and presents the
// encoded index until acknowledged; non-one-hot patterns produce an err pulse.
module onehot_select_encoder
  import onehot_enc_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] sel_in,
  input  logic       ack,
  output logic [2:0] code,
  output logic       code_valid,
  output logic       err
);

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

  logic [SEL_W-1:0]  sync_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  cand_q, cand_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              settle_done;

  bit_synchronizer #(
    .WIDTH (SEL_W),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sel_in),
    .q     (sync_q)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    code_d      = code_q;
    valid_d     = valid_q;
    err_d       = 1'b0;
    settle_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (sync_q != '0) begin
          cand_d      = sync_q;
          cnt_d       = CNT_W'(1);
          state_d     = SETTLE;
          settle_done = (cnt_d == STABLE_MAX);
        end
      end
      SETTLE: begin
        if (sync_q == '0) begin
          state_d = IDLE;
        end else if (sync_q != cand_q) begin
          cand_d = sync_q;
          cnt_d  = CNT_W'(1);
        end else begin
          // Counter saturates at the threshold instead of wrapping.
          cnt_d       = (cnt_q < STABLE_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
          settle_done = (cnt_d == STABLE_MAX);
        end
      end
      HOLD: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (sync_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (settle_done) begin
      if (is_onehot(cand_d)) begin
        code_d  = encode(cand_d);
        valid_d = 1'b1;
        state_d = HOLD;
      end else begin
        code_d  = ERR_CODE;
        err_d   = 1'b1;
        state_d = RELEASE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign code       = code_q;
  assign code_valid = valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_onehot_select_encoder.sv
// Directed self-checking bench for onehot_select_encoder with default parameters.
module tb_onehot_select_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] sel_in;
  logic       ack;
  logic [2:0] code;
  logic       code_valid;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;

  onehot_select_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .sel_in     (sel_in),
    .ack        (ack),
    .code       (code),
    .code_valid (code_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err) err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until code_valid is seen high; 40 means it never rose.
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (code_valid) break;
    end
  endtask

  task automatic wait_err(output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (err) break;
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  int n;
  int err_before;
  logic [6:0] pat;

  initial begin
    reset  = 1'b1;
    sel_in = '0;
    ack    = 1'b0;
    tick(3);
    check("reset_code", code, 3'b000);
    check("reset_valid", code_valid, 1'b0);
    check("reset_err", err, 1'b0);
    reset = 1'b0;
    tick(2);

    // Basic acceptance and acknowledge
    sel_in = 7'b0001000;
    wait_valid(n);
    check("b3_latency", n, 6);
    check("b3_code", code, 3'b011);
    do_ack();
    check("b3_ack_clear", code_valid, 1'b0);
    check("b3_code_kept", code, 3'b011);
    sel_in = '0;
    tick(4);

    // Candidate switch restarts settling
    sel_in = 7'b0000100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sw_no_early_valid", code_valid, 1'b0);
    end
    sel_in = 7'b0100000;
    wait_valid(n);
    check("sw_latency", n, 6);
    check("sw_code", code, 3'b101);
    do_ack();
    sel_in = '0;
    tick(4);

    // Non-one-hot pattern
    err_before = err_cnt;
    sel_in = 7'b0010010;
    wait_err(n);
    check("nh_err_latency", n, 6);
    check("nh_err_code", code, 3'b111);
    check("nh_err_valid", code_valid, 1'b0);
    tick();
    check("nh_err_pulse_end", err, 1'b0);
    tick(8);
    check("nh_no_accept", code_valid, 1'b0);
    check("nh_err_count", err_cnt - err_before, 1);
    sel_in = '0;
    tick(4);
    sel_in = 7'b1000000;
    wait_valid(n);
    check("nh_after_latency", n, 6);
    check("nh_after_code", code, 3'b110);
    do_ack();
    sel_in = '0;
    tick(4);

    // HOLD ignores sel_in changes; RELEASE waits for all-zero
    sel_in = 7'b0000001;
    wait_valid(n);
    check("hold_code0", code, 3'b000);
    sel_in = 7'b0000010;
    tick(10);
    check("hold_code_stays", code, 3'b000);
    check("hold_valid_stays", code_valid, 1'b1);
    do_ack();
    check("hold_ack_clear", code_valid, 1'b0);
    tick(12);
    check("rel_no_new_valid", code_valid, 1'b0);
    check("rel_code_kept", code, 3'b000);
    sel_in = '0;
    tick(4);

    // Asynchronous reset mid-HOLD
    sel_in = 7'b0100000;
    wait_valid(n);
    check("rst_pre_code", code, 3'b101);
    #2 reset = 1'b1;
    #1;
    check("rst_async_code", code, 3'b000);
    check("rst_async_valid", code_valid, 1'b0);
    check("rst_async_err", err, 1'b0);
    sel_in = 7'b0000001;
    tick(2);
    reset = 1'b0;
    wait_valid(n);
    check("rst_after_latency", n, 6);
    check("rst_after_code", code, 3'b000);
    do_ack();
    sel_in = '0;
    tick(4);

    // All seven codes in order
    err_before = err_cnt;
    for (int k = 0; k < 7; k++) begin
      pat = 7'(1 << k);
      sel_in = pat;
      wait_valid(n);
      check("seq_latency", n, 6);
      check("seq_code", code, k);
      do_ack();
      check("seq_ack_clear", code_valid, 1'b0);
      sel_in = '0;
      tick(4);
    end
    check("seq_no_err", err_cnt - err_before, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_select_encoder.md
ONEHOT_SELECT_ENCODER -- requirements
Module: onehot_select_encoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the number of synchronizer flops per sel_in bit (legal range 2..4).
REQ-002 Parameter STABLE_CYCLES, default 4, sets the consecutive identical synchronized samples needed before acceptance (legal range 1..255).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 sel_in  input  7  one-hot select lines, asynchronous to clk; bit k requests code k.
REQ-006 ack  input  1  consumer acknowledge of the presented code.
REQ-007 code  output  3  encoded index of the accepted one-hot input.
REQ-008 code_valid  output  1  code is stable and unacknowledged.
REQ-009 err  output  1  one-cycle pulse for an accepted non-one-hot pattern.

Function
REQ-010 The encoding SHALL be the inverse of the 3-to-7 one-hot map: bit0->000, bit1->001, bit2->010, bit3->011, bit4->100, bit5->101, bit6->110.
REQ-011 Every sel_in bit SHALL pass through SYNC_STAGES flops before any other logic uses it; the result is sync_q[6:0].
REQ-012 The FSM SHALL have four states: IDLE, SETTLE, HOLD, RELEASE.
REQ-013 IDLE: when sync_q is nonzero, the FSM SHALL load the stability counter with 1, capture sync_q as the candidate, and go to SETTLE.
REQ-014 SETTLE, sync_q differs from the candidate but is nonzero: the FSM SHALL recapture the candidate, reset the counter to 1, and stay in SETTLE.
REQ-015 SETTLE, sync_q is zero: the FSM SHALL return to IDLE with no output change.
REQ-016 SETTLE, sync_q equals the candidate and the counter reaches STABLE_CYCLES: the FSM SHALL either register code and set code_valid=1 and go to HOLD (candidate one-hot), or pulse err for exactly one cycle, set code=3'b111, and go to RELEASE (candidate not one-hot).
REQ-017 Latency SHALL be exactly SYNC_STAGES+STABLE_CYCLES rising edges from the first edge sampling a new stable sel_in to code_valid high (6 with defaults).
REQ-018 HOLD: code and code_valid SHALL stay constant regardless of sel_in; ack=1 SHALL clear code_valid on the next edge and move the FSM to RELEASE.
REQ-019 RELEASE: the FSM SHALL wait for sync_q to be zero for one sample, then go to IDLE; code SHALL retain its last value.
REQ-020 ack in any state other than HOLD SHALL be ignored.
REQ-021 ack in HOLD with sync_q already zero SHALL still pass through RELEASE, giving one cycle in RELEASE before IDLE.
REQ-022 The stability counter SHALL saturate at STABLE_CYCLES and never wrap.
REQ-023 A new code SHALL never be accepted without sel_in first returning to all-zero.

Reset
REQ-024 While reset=1, the block SHALL immediately force state=IDLE, code=3'b000, code_valid=0, err=0, counter=0, candidate=0, and all synchronizer flops to 0.
REQ-025 Reset asserted mid-SETTLE or mid-HOLD SHALL discard the candidate; after release, the block SHALL require full re-synchronization and settling.

Structure
REQ-026 The shared package onehot_enc_pkg SHALL hold the state enum, the code width (3), the select width (7), the error code 3'b111, and the parameter defaults.
REQ-027 A single sub-module bit_synchronizer (width and depth parameterized, asynchronous active-high reset to 0) SHALL implement REQ-011.
REQ-028 Outputs code, code_valid, and err SHALL be driven directly from flops.

Verification
REQ-029 sel_in=7'b0001000 held, ack after code_valid -> code_valid rises exactly 6 edges after the first sample, code=3'b011, code_valid clears 1 edge after ack.
REQ-030 sel_in=7'b0000100 for 3 cycles then 7'b0100000 held -> no code_valid for 0000100; code=3'b101 accepted 6 edges after the switch.
REQ-031 sel_in=7'b0010010 held -> err high for exactly 1 cycle, code=3'b111, code_valid stays 0; no acceptance until sel_in=0 and then 7'b1000000, which gives code=3'b110.
REQ-032 In HOLD with code=3'b000, sel_in changes to 7'b0000010 -> code stays 3'b000; after ack with sel_in still nonzero, the FSM stays in RELEASE and no new code_valid appears.
REQ-033 reset asserted asynchronously mid-HOLD -> outputs become 000/0/0 without a clock edge; after release, a held 7'b0000001 gives code_valid after 6 edges with code=3'b000.
REQ-034 All seven one-hot inputs in sequence, each followed by ack and release -> codes 000 through 110 in order, err never asserted.
